// File: rtl/vote_arbiter.sv
// Round-robin front end for the vote-tally counter: arbitrates two booths,
// validates the latched vote word against its group and pulses one counter update.
module vote_arbiter (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       open_cmd,
    input  logic       close_cmd,
    input  logic       req0,
    input  logic       req1,
    input  logic [4:0] word0,
    input  logic [4:0] word1,
    input  logic       sel0,
    input  logic       sel1,
    input  logic       mode0,
    input  logic       mode1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       nack0,
    output logic       nack1,
    output logic       cnt_en,
    output logic [4:0] cnt_word,
    output logic       cnt_selection,
    output logic       cnt_mode,
    output logic       session_open,
    output logic [7:0] accepted,
    output logic [7:0] rejected
);

    typedef enum logic [1:0] {CLOSED, ARB, CHECK, WAIT} state_t;

    state_t state, state_n;
    logic   ptr;
    logic   served;
    logic   pick1;
    logic   served_req;
    logic   vote_ok;

    // sel=0 needs an adjacent 00 pair, sel=1 an adjacent 11 pair
    function automatic logic word_valid(input logic [4:0] w, input logic s);
        logic v;
        v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s) v = v | (w[i] & w[i+1]);
            else   v = v | (~w[i] & ~w[i+1]);
        end
        return v;
    endfunction

    assign pick1      = req1 & (~req0 | ptr);
    assign served_req = served ? req1 : req0;
    assign vote_ok    = word_valid(cnt_word, cnt_selection);

    always_comb begin
        state_n = state;
        case (state)
            CLOSED: if (open_cmd && !close_cmd) state_n = ARB;
            ARB: begin
                if (close_cmd)         state_n = CLOSED;
                else if (req0 || req1) state_n = CHECK;
            end
            CHECK:  state_n = WAIT;
            WAIT:   if (!served_req) state_n = ARB;
            default: state_n = CLOSED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= CLOSED;
            ptr           <= 1'b0;
            served        <= 1'b0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            nack0         <= 1'b0;
            nack1         <= 1'b0;
            cnt_en        <= 1'b0;
            cnt_word      <= '0;
            cnt_selection <= 1'b0;
            cnt_mode      <= 1'b0;
            session_open  <= 1'b0;
            accepted      <= '0;
            rejected      <= '0;
        end else begin
            state        <= state_n;
            session_open <= (state_n != CLOSED);
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            nack0        <= 1'b0;
            nack1        <= 1'b0;
            cnt_en       <= 1'b0;
            case (state)
                CLOSED: begin
                    if (state_n == ARB) begin
                        accepted <= '0;
                        rejected <= '0;
                    end
                end
                ARB: begin
                    if (state_n == CHECK) begin
                        served        <= pick1;
                        cnt_word      <= pick1 ? word1 : word0;
                        cnt_selection <= pick1 ? sel1  : sel0;
                        cnt_mode      <= pick1 ? mode1 : mode0;
                    end
                end
                CHECK: begin
                    if (vote_ok) begin
                        cnt_en <= 1'b1;
                        gnt0   <= ~served;
                        gnt1   <= served;
                        if (accepted != 8'hFF) accepted <= accepted + 8'd1;
                    end else begin
                        nack0  <= ~served;
                        nack1  <= served;
                        if (rejected != 8'hFF) rejected <= rejected + 8'd1;
                    end
                    ptr <= ~served;
                end
                default: ;
            endcase
        end
    end

endmodule
